// File: rtl/tow_pkg.sv
// Shared types and constants for the tug-of-war round/match controller.
package tow_pkg;

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } tow_state_t;

    localparam int SCORE_W = 3;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_L    = 2'b01;
    localparam logic [1:0] WIN_R    = 2'b10;

endpackage

// File: rtl/key_conditioner.sv
// Synchronizes one raw player key and emits a single-cycle pulse per press.
module key_conditioner (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic pulse
);

    logic       sync1_q;
    logic       sync2_q;
    logic       prev_q;
    logic       armed_q;
    logic [1:0] vld_q;

    // NOTE: non-blocking assignments make every stage take the previous stage's old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            vld_q   <= 2'b00;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            vld_q   <= {vld_q[0], 1'b1};
            // Arm only after a genuine released sample, so a key held through reset stays silent.
            if (vld_q[1] && !sync2_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign pulse = armed_q & sync2_q & ~prev_q;

endmodule

// File: rtl/tow_referee.sv
// Round/match controller: gates key pulses, detects round wins, keeps scores, drives game_over.
module tow_referee
    import tow_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int MAX_SCORE   = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key_l_raw,
    input  logic               key_r_raw,
    input  logic               edge_l,
    input  logic               edge_r,
    output logic               L,
    output logic               R,
    output logic               game_over,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic [1:0]         winner,
    output logic               match_over
);

    localparam int                   HOLD_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0]    HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [SCORE_W-1:0]   MAX_S     = SCORE_W'(MAX_SCORE);

    tow_state_t         state_q;
    logic [HOLD_W-1:0]  hold_q;
    logic [SCORE_W-1:0] score_l_q;
    logic [SCORE_W-1:0] score_r_q;
    logic [1:0]         winner_q;
    logic               game_over_q;
    logic               match_over_q;

    logic pulse_l;
    logic pulse_r;
    logic win_l;
    logic win_r;
    logic max_l;
    logic max_r;

    key_conditioner u_key_l (
        .clk   (clk),
        .reset (reset),
        .raw   (key_l_raw),
        .pulse (pulse_l)
    );

    key_conditioner u_key_r (
        .clk   (clk),
        .reset (reset),
        .raw   (key_r_raw),
        .pulse (pulse_r)
    );

    // Presses outside PLAY are dropped here, never queued.
    assign L     = pulse_l & (state_q == PLAY);
    assign R     = pulse_r & (state_q == PLAY);
    assign win_l = edge_l & L & ~R;
    assign win_r = edge_r & R & ~L;
    assign max_l = (score_l_q == MAX_S);
    assign max_r = (score_r_q == MAX_S);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= PLAY;
            hold_q       <= '0;
            score_l_q    <= '0;
            score_r_q    <= '0;
            winner_q     <= WIN_NONE;
            game_over_q  <= 1'b0;
            match_over_q <= 1'b0;
        end else begin
            case (state_q)
                PLAY: begin
                    if (win_l) begin
                        score_l_q   <= score_l_q + 1'b1;
                        hold_q      <= HOLD_LOAD;
                        game_over_q <= 1'b1;
                        state_q     <= HOLD;
                    end else if (win_r) begin
                        score_r_q   <= score_r_q + 1'b1;
                        hold_q      <= HOLD_LOAD;
                        game_over_q <= 1'b1;
                        state_q     <= HOLD;
                    end
                end
                HOLD: begin
                    if (hold_q == '0) begin
                        if (max_l || max_r) begin
                            state_q      <= DONE;
                            match_over_q <= 1'b1;
                            winner_q     <= max_l ? WIN_L : WIN_R;
                        end else begin
                            state_q     <= PLAY;
                            game_over_q <= 1'b0;
                        end
                    end else begin
                        hold_q <= hold_q - 1'b1;
                    end
                end
                DONE: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q <= PLAY;
                end
            endcase
        end
    end

    assign game_over  = game_over_q;
    assign match_over = match_over_q;
    assign winner     = winner_q;
    assign score_l    = score_l_q;
    assign score_r    = score_r_q;

endmodule

// File: tb/tb_tow_referee.sv
// Directed self-checking bench for tow_referee (default build plus a 1-cycle-hold, 1-point build).
module tb_tow_referee;

    logic       clk = 1'b0;
    logic       reset, key_l, key_r, edge_l, edge_r;
    logic       l_o, r_o, go, mo;
    logic [2:0] sl, sr;
    logic [1:0] win;

    logic       reset2, key_l2, key_r2, edge_l2, edge_r2;
    logic       l2, r2, go2, mo2;
    logic [2:0] sl2, sr2;
    logic [1:0] win2;

    int n_checks = 0;
    int n_pass   = 0;
    int extra;

    always #5 clk = ~clk;

    tow_referee dut (
        .clk(clk), .reset(reset), .key_l_raw(key_l), .key_r_raw(key_r),
        .edge_l(edge_l), .edge_r(edge_r), .L(l_o), .R(r_o), .game_over(go),
        .score_l(sl), .score_r(sr), .winner(win), .match_over(mo)
    );

    tow_referee #(.HOLD_CYCLES(1), .MAX_SCORE(1)) dut2 (
        .clk(clk), .reset(reset2), .key_l_raw(key_l2), .key_r_raw(key_r2),
        .edge_l(edge_l2), .edge_r(edge_r2), .L(l2), .R(r2), .game_over(go2),
        .score_l(sl2), .score_r(sr2), .winner(win2), .match_over(mo2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Right press with edge_r already high: pulse, then a full 4-cycle hold.
    task automatic right_win();
        key_r = 1'b1;
        tick();
        tick();
        key_r = 1'b0;
        tick();
        repeat (4) tick();
    endtask

    initial begin
        reset = 1'b1; key_l = 1'b0; key_r = 1'b0; edge_l = 1'b0; edge_r = 1'b0;
        reset2 = 1'b1; key_l2 = 1'b0; key_r2 = 1'b0; edge_l2 = 1'b0; edge_r2 = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        repeat (4) tick();

        check("rst_L", l_o, 0);
        check("rst_R", r_o, 0);
        check("rst_game_over", go, 0);
        check("rst_scores", {sl, sr}, 0);
        check("rst_winner", win, 0);
        check("rst_match_over", mo, 0);

        // Long key hold: one pulse, one cycle after the synchronizer's first sample.
        key_l = 1'b1;
        tick();
        check("press_L_early", l_o, 0);
        tick();
        check("press_L_pulse", l_o, 1);
        check("press_R_quiet", r_o, 0);
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            extra += int'(l_o) + int'(r_o);
        end
        check("press_single_pulse", extra, 0);
        key_l = 1'b0;
        repeat (3) tick();

        // Left round win.
        edge_l = 1'b1;
        key_l  = 1'b1;
        tick();
        tick();
        check("lwin_L", l_o, 1);
        check("lwin_go_before", go, 0);
        tick();
        check("lwin_score_l", sl, 1);
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            check("lwin_go_hold", go, 1);
            extra += int'(l_o) + int'(r_o);
        end
        check("lwin_no_pulse_hold", extra, 0);
        key_l  = 1'b0;
        edge_l = 1'b0;
        tick();
        check("lwin_go_after", go, 0);
        check("lwin_score_r", sr, 0);
        check("lwin_mo", mo, 0);
        repeat (3) tick();

        // Simultaneous presses with right end light on: no win.
        edge_r = 1'b1;
        key_l  = 1'b1;
        key_r  = 1'b1;
        tick();
        tick();
        check("simul_LR", {l_o, r_o}, 2'b11);
        tick();
        check("simul_go", go, 0);
        check("simul_scores", {sl, sr}, {3'd1, 3'd0});
        key_l = 1'b0;
        key_r = 1'b0;
        repeat (3) tick();

        // Seven right wins end the match.
        for (int w = 0; w < 6; w++) right_win();
        check("r6_score_r", sr, 6);
        check("r6_go", go, 0);
        check("r6_mo", mo, 0);
        right_win();
        check("done_score_r", sr, 7);
        check("done_score_l", sl, 1);
        check("done_winner", win, 2'b10);
        check("done_mo", mo, 1);
        check("done_go", go, 1);
        key_l = 1'b1;
        key_r = 1'b1;
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            extra += int'(l_o) + int'(r_o);
        end
        check("done_no_pulses", extra, 0);
        check("done_scores_kept", {sl, sr}, {3'd1, 3'd7});
        check("done_still_mo", mo, 1);
        key_l  = 1'b0;
        key_r  = 1'b0;
        edge_r = 1'b0;

        // Reset in the second hold cycle while the left key stays held.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (4) tick();
        edge_l = 1'b1;
        key_l  = 1'b1;
        tick();
        tick();
        tick();
        check("mid_hold1_go", go, 1);
        tick();
        check("mid_hold2_go", go, 1);
        reset  = 1'b1;
        edge_l = 1'b0;
        tick();
        reset = 1'b0;
        check("mid_rst_outputs", {l_o, r_o, go, sl, sr, win, mo}, 0);
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            extra += int'(l_o);
        end
        check("held_key_silent", extra, 0);
        key_l = 1'b0;
        repeat (4) tick();
        key_l = 1'b1;
        tick();
        tick();
        check("repress_L", l_o, 1);
        key_l = 1'b0;
        tick();

        // Second build: HOLD_CYCLES=1, MAX_SCORE=1.
        reset2 = 1'b0;
        repeat (4) tick();
        edge_l2 = 1'b1;
        key_l2  = 1'b1;
        tick();
        tick();
        check("b2_L", l2, 1);
        tick();
        check("b2_hold_go", go2, 1);
        check("b2_hold_score", sl2, 1);
        check("b2_hold_mo", mo2, 0);
        tick();
        check("b2_done_go", go2, 1);
        check("b2_done_mo", mo2, 1);
        check("b2_done_winner", win2, 2'b01);
        check("b2_done_L", l2, 0);
        check("b2_score_r", sr2, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
